// File: rtl/fb_store_if.sv
// Pixel read port, host write port and clear-control signals of the frame-buffer store.
// The master modport is the requester side; the slave modport is the storage block.
interface fb_store_if #(
  parameter int unsigned ADDR_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned LevelW = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_BITS-1:0] vc_row_address;
  logic [ADDR_BITS-1:0] vc_col_address;
  logic                 vc_request;
  logic [23:0]          vc_read_data;

  logic                 wr_valid;
  logic                 wr_ready;
  logic [ADDR_BITS-1:0] wr_row;
  logic [ADDR_BITS-1:0] wr_col;
  logic [23:0]          wr_data;

  logic                 clr_start;
  logic [23:0]          clr_colour;
  logic                 clr_busy;
  logic [LevelW-1:0]    fifo_level;

  modport master (
    output vc_row_address, vc_col_address, vc_request,
    output wr_valid, wr_row, wr_col, wr_data,
    output clr_start, clr_colour,
    input  vc_read_data, wr_ready, clr_busy, fifo_level
  );

  modport slave (
    input  vc_row_address, vc_col_address, vc_request,
    input  wr_valid, wr_row, wr_col, wr_data,
    input  clr_start, clr_colour,
    output vc_read_data, wr_ready, clr_busy, fifo_level
  );
endinterface

// File: rtl/fb_store.sv
// Single-port 24-bit frame buffer: zero-latency VGA reads win every cycle, host writes drain
// from a small FIFO on idle cycles, and a clear engine fills the array with one colour.
module fb_store #(
  parameter int unsigned ADDR_BITS  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  fb_store_if.slave bus
);
  localparam int unsigned AddrW  = 2 * ADDR_BITS;
  localparam int unsigned Words  = 1 << AddrW;
  localparam int unsigned PtrW   = $clog2(FIFO_DEPTH);
  localparam int unsigned LevelW = PtrW + 1;
  localparam int unsigned EntryW = AddrW + 24;

  typedef enum logic [1:0] {StIdle, StDrain, StFill} state_e;

  state_e             state_q, state_d;
  logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [LevelW-1:0]  level_q, level_d;
  logic [AddrW-1:0]   fill_cnt_q, fill_cnt_d;
  logic [23:0]        colour_q, colour_d;

  logic [23:0]        mem [Words];
  logic [EntryW-1:0]  fifo_mem [FIFO_DEPTH];

  logic               wr_ready;
  logic               push;
  logic               pop;
  logic               fill_wr;
  logic               mem_we;
  logic [AddrW-1:0]   mem_waddr;
  logic [23:0]        mem_wdata;
  logic [AddrW-1:0]   rd_addr;
  logic [EntryW-1:0]  head;

  // Read path is purely combinational so the controller can capture on the next edge.
  assign rd_addr          = {bus.vc_row_address, bus.vc_col_address};
  assign bus.vc_read_data = bus.vc_request ? mem[rd_addr] : 24'h000000;

  // No bypass: a full FIFO refuses a push even when it pops in the same cycle.
  assign wr_ready       = (level_q < LevelW'(FIFO_DEPTH)) && (state_q == StIdle);
  assign push           = bus.wr_valid && wr_ready;
  assign pop            = !bus.vc_request && (level_q != '0) && (state_q != StFill);
  assign head           = fifo_mem[rd_ptr_q];

  assign bus.wr_ready   = wr_ready;
  assign bus.clr_busy   = (state_q != StIdle);
  assign bus.fifo_level = level_q;

  always_comb begin
    state_d    = state_q;
    colour_d   = colour_q;
    fill_cnt_d = fill_cnt_q;
    fill_wr    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.clr_start) begin
          state_d  = StDrain;
          colour_d = bus.clr_colour;
        end
      end
      StDrain: begin
        if (level_q == '0) begin
          state_d    = StFill;
          fill_cnt_d = '0;
        end
      end
      StFill: begin
        if (!bus.vc_request) begin
          fill_wr    = 1'b1;
          fill_cnt_d = fill_cnt_q + 1'b1;
          if (&fill_cnt_q) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + PtrW'(pop);
    wr_ptr_d = wr_ptr_q + PtrW'(push);
    level_d  = level_q + LevelW'(push) - LevelW'(pop);
  end

  // FIFO pop and fill writes are mutually exclusive, so one port suffices.
  assign mem_we    = pop || fill_wr;
  assign mem_waddr = fill_wr ? fill_cnt_q : head[EntryW-1:24];
  assign mem_wdata = fill_wr ? colour_q : head[23:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      level_q    <= '0;
      fill_cnt_q <= '0;
      colour_q   <= '0;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      level_q    <= level_d;
      fill_cnt_q <= fill_cnt_d;
      colour_q   <= colour_d;
    end
  end

  // Storage arrays carry no reset; the pointers above define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= {bus.wr_row, bus.wr_col, bus.wr_data};
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  a_level_bound: assert property (@(posedge clk) disable iff (!reset)
    level_q <= LevelW'(FIFO_DEPTH));
  a_no_pop_empty: assert property (@(posedge clk) disable iff (!reset)
    pop |-> (level_q != '0));
endmodule

// File: tb/tb_fb_store.sv
// Bench for fb_store: a 256x256 instance for host-write ordering and a 4x4 instance for clear.
// A queue-level model is checked every cycle; directed literals pin the model's key results.
module tb_fb_store;
  localparam int FifoDepth = 4;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  fb_store_if #(.ADDR_BITS(8), .FIFO_DEPTH(FifoDepth)) bus8 ();
  fb_store_if #(.ADDR_BITS(2), .FIFO_DEPTH(FifoDepth)) bus2 ();

  fb_store #(.ADDR_BITS(8), .FIFO_DEPTH(FifoDepth)) dut8 (.clk(clk), .reset(reset), .bus(bus8));
  fb_store #(.ADDR_BITS(2), .FIFO_DEPTH(FifoDepth)) dut2 (.clk(clk), .reset(reset), .bus(bus2));

  // Stimulus and observation, index 0 = 8-bit instance, 1 = 2-bit instance.
  logic        vreq [2];
  logic [7:0]  vrow [2];
  logic [7:0]  vcol [2];
  logic        wv   [2];
  logic [7:0]  wrow [2];
  logic [7:0]  wcol [2];
  logic [23:0] wdat [2];
  logic        cs   [2];
  logic [23:0] ccol [2];

  logic [23:0] rd   [2];
  logic        rdy  [2];
  logic        busy [2];
  logic [2:0]  lvl  [2];

  assign bus8.vc_request     = vreq[0];
  assign bus8.vc_row_address = vrow[0];
  assign bus8.vc_col_address = vcol[0];
  assign bus8.wr_valid       = wv[0];
  assign bus8.wr_row         = wrow[0];
  assign bus8.wr_col         = wcol[0];
  assign bus8.wr_data        = wdat[0];
  assign bus8.clr_start      = cs[0];
  assign bus8.clr_colour     = ccol[0];
  assign rd[0]   = bus8.vc_read_data;
  assign rdy[0]  = bus8.wr_ready;
  assign busy[0] = bus8.clr_busy;
  assign lvl[0]  = bus8.fifo_level;

  assign bus2.vc_request     = vreq[1];
  assign bus2.vc_row_address = vrow[1][1:0];
  assign bus2.vc_col_address = vcol[1][1:0];
  assign bus2.wr_valid       = wv[1];
  assign bus2.wr_row         = wrow[1][1:0];
  assign bus2.wr_col         = wcol[1][1:0];
  assign bus2.wr_data        = wdat[1];
  assign bus2.clr_start      = cs[1];
  assign bus2.clr_colour     = ccol[1];
  assign rd[1]   = bus2.vc_read_data;
  assign rdy[1]  = bus2.wr_ready;
  assign busy[1] = bus2.clr_busy;
  assign lvl[1]  = bus2.fifo_level;

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: memory image with a known-bitmap, FIFO as an ordered list, clear as a mode + index.
  int          ab       [2];
  logic [23:0] mem_m    [2][65536];
  bit          known_m  [2][65536];
  int          fidx_m   [2][FifoDepth];
  logic [23:0] fdat_m   [2][FifoDepth];
  int          cnt_m    [2];
  int          mode_m   [2];  // 0 idle, 1 draining, 2 filling
  int          ctr_m    [2];
  logic [23:0] col_m    [2];

  always @(negedge clk) begin : compare
    int idx;
    int words;
    int start_cnt;
    for (int k = 0; k < 2; k++) begin
      words = 1 << (2 * ab[k]);
      if (!reset) begin
        cnt_m[k]  = 0;
        mode_m[k] = 0;
        ctr_m[k]  = 0;
        col_m[k]  = '0;
        chk("reset_wr_ready", 32'(rdy[k]), 32'd1);
        chk("reset_clr_busy", 32'(busy[k]), 32'd0);
        chk("reset_fifo_level", 32'(lvl[k]), 32'd0);
      end else begin
        idx = int'(vrow[k]) * (1 << ab[k]) + int'(vcol[k]);
        chk("wr_ready", 32'(rdy[k]), 32'(cnt_m[k] < FifoDepth && mode_m[k] == 0));
        chk("clr_busy", 32'(busy[k]), 32'(mode_m[k] != 0));
        chk("fifo_level", 32'(lvl[k]), 32'(cnt_m[k]));
        if (!vreq[k]) chk("read_idle_zero", 32'(rd[k]), 32'd0);
        else if (known_m[k][idx]) chk("read_data", 32'(rd[k]), 32'(mem_m[k][idx]));

        // Advance the model to the state after the coming rising edge.
        start_cnt = cnt_m[k];
        if (!vreq[k] && cnt_m[k] > 0 && mode_m[k] != 2) begin
          mem_m[k][fidx_m[k][0]]   = fdat_m[k][0];
          known_m[k][fidx_m[k][0]] = 1'b1;
          for (int j = 0; j < FifoDepth - 1; j++) begin
            fidx_m[k][j] = fidx_m[k][j+1];
            fdat_m[k][j] = fdat_m[k][j+1];
          end
          cnt_m[k]--;
        end
        if (wv[k] && start_cnt < FifoDepth && mode_m[k] == 0) begin
          fidx_m[k][cnt_m[k]] = int'(wrow[k]) * (1 << ab[k]) + int'(wcol[k]);
          fdat_m[k][cnt_m[k]] = wdat[k];
          cnt_m[k]++;
        end
        case (mode_m[k])
          0: if (cs[k]) begin
            mode_m[k] = 1;
            col_m[k]  = ccol[k];
          end
          1: if (start_cnt == 0) begin
            mode_m[k] = 2;
            ctr_m[k]  = 0;
          end
          default: if (!vreq[k]) begin
            mem_m[k][ctr_m[k]]   = col_m[k];
            known_m[k][ctr_m[k]] = 1'b1;
            if (ctr_m[k] == words - 1) mode_m[k] = 0;
            else ctr_m[k]++;
          end
        endcase
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input int k, input int r, input int c, input logic [23:0] exp,
                          input string name);
    vreq[k] = 1'b1;
    vrow[k] = 8'(r);
    vcol[k] = 8'(c);
    #1;
    chk(name, 32'(rd[k]), 32'(exp));
    step();
  endtask

  initial begin
    int n;
    ab[0] = 8;
    ab[1] = 2;
    for (int k = 0; k < 2; k++) begin
      vreq[k] = 1'b0; vrow[k] = '0; vcol[k] = '0;
      wv[k] = 1'b0; wrow[k] = '0; wcol[k] = '0; wdat[k] = '0;
      cs[k] = 1'b0; ccol[k] = '0;
      cnt_m[k] = 0; mode_m[k] = 0; ctr_m[k] = 0; col_m[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    step();

    // Single write commits one edge after it is pushed.
    wv[0] = 1'b1; wrow[0] = 8'd3; wcol[0] = 8'd5; wdat[0] = 24'hFF0000;
    step();
    chk("t1_level_after_push", 32'(lvl[0]), 32'd1);
    wv[0] = 1'b0;
    step();
    chk("t1_level_after_commit", 32'(lvl[0]), 32'd0);
    read_chk(0, 3, 5, 24'hFF0000, "t1_read_3_5");

    // Fill the FIFO while reads hold the port, then let it drain in order.
    vreq[0] = 1'b1; vrow[0] = 8'd3; vcol[0] = 8'd5;
    for (int i = 0; i < 4; i++) begin
      wv[0] = 1'b1; wrow[0] = 8'(10 + i); wcol[0] = 8'(20 + i); wdat[0] = 24'hA00001 + 24'(i);
      step();
    end
    chk("t2_level_full", 32'(lvl[0]), 32'd4);
    chk("t2_ready_full", 32'(rdy[0]), 32'd0);
    wrow[0] = 8'd10; wcol[0] = 8'd20; wdat[0] = 24'hDEAD00;
    step();
    chk("t2_fifth_refused", 32'(lvl[0]), 32'd4);
    wv[0] = 1'b0; vreq[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("t2_drain_level", 32'(lvl[0]), 32'(3 - i));
    end
    for (int i = 0; i < 4; i++) read_chk(0, 10 + i, 20 + i, 24'hA00001 + 24'(i), "t2_read");
    vreq[0] = 1'b0;

    // Back-to-back writes to one address: last one wins, push+pop keeps level.
    wv[0] = 1'b1; wrow[0] = 8'd7; wcol[0] = 8'd7; wdat[0] = 24'h111111;
    step();
    wdat[0] = 24'h222222;
    step();
    chk("t3_push_pop_level", 32'(lvl[0]), 32'd1);
    wv[0] = 1'b0;
    step();
    read_chk(0, 7, 7, 24'h222222, "t3_last_wins");
    vreq[0] = 1'b0;

    // Clear on the 4x4 instance with two writes queued ahead of it.
    vreq[1] = 1'b1;
    wv[1] = 1'b1; wrow[1] = 8'd1; wcol[1] = 8'd1; wdat[1] = 24'hAAAAAA;
    step();
    wrow[1] = 8'd2; wcol[1] = 8'd3; wdat[1] = 24'hBBBBBB;
    step();
    wv[1] = 1'b0; cs[1] = 1'b1; ccol[1] = 24'h00FF00;
    step();
    chk("t4_busy", 32'(busy[1]), 32'd1);
    chk("t4_ready_low", 32'(rdy[1]), 32'd0);
    ccol[1] = 24'hFF0000;  // a second start while busy must not change the colour
    step();
    cs[1] = 1'b0; vreq[1] = 1'b0;
    n = 0;
    do begin
      step();
      n++;
    end while (busy[1] && n < 100);
    chk("t4_clear_edges", 32'(n), 32'd19);
    for (int i = 0; i < 16; i++) read_chk(1, i / 4, i % 4, 24'h00FF00, "t4_fill_read");
    vreq[1] = 1'b0;

    // Clear with reads on every other cycle: the fill stretches to 32 edges.
    cs[1] = 1'b1; ccol[1] = 24'h0000FF;
    step();
    cs[1] = 1'b0;
    step();
    chk("t5_busy_fill", 32'(busy[1]), 32'd1);
    n = 0;
    do begin
      vreq[1] = (n % 2 == 0);
      vrow[1] = 8'(((n / 2 + 15) % 16) / 4);
      vcol[1] = 8'(((n / 2 + 15) % 16) % 4);
      step();
      n++;
    end while (busy[1] && n < 100);
    chk("t5_toggle_edges", 32'(n), 32'd32);
    read_chk(1, 3, 3, 24'h0000FF, "t5_read_last");
    vreq[1] = 1'b0;

    // Reset during fill at index 5, with writes pending on the large instance.
    cs[1] = 1'b1; ccol[1] = 24'hFF00FF;
    step();
    cs[1] = 1'b0;
    step();
    vreq[0] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wv[0] = (i < 2); wrow[0] = 8'(50 + i); wcol[0] = 8'(50 + i); wdat[0] = 24'h123456;
      step();
    end
    wv[0] = 1'b0;
    chk("t6_pending_before_reset", 32'(lvl[0]), 32'd2);
    reset = 1'b0;
    vreq[0] = 1'b0;
    #1;
    chk("t6_busy_in_reset", 32'(busy[1]), 32'd0);
    chk("t6_level2_in_reset", 32'(lvl[1]), 32'd0);
    chk("t6_level8_in_reset", 32'(lvl[0]), 32'd0);
    step();
    reset = 1'b1;
    step();
    chk("t6_no_stale_commit", 32'(lvl[0]), 32'd0);
    for (int i = 0; i < 16; i++)
      read_chk(1, i / 4, i % 4, (i < 5) ? 24'hFF00FF : 24'h0000FF, "t6_partial_fill");
    vreq[1] = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
